fpu_decode_queue: RTL and testbench

- Parametrised successor to the single-instruction FPU decoder.
- Claims RV F/D-extension instructions, including LOAD-FP, STORE-FP and OP-FP.
- Decodes each claimed instruction into a record, resolves the rounding mode and flags illegal encodings.
- Buffers records in a DEPTH-entry FIFO with valid/ready handshakes on both sides, between risc_mgmt decode and the FPU execute stage.

---
 rtl/fpu_decode_queue.sv | 207 ++++++++++++++++++++
 tb/tb_fpu_decode_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_decode_queue.sv
// fpu_decode_queue: claims RV F/D-extension instructions (LOAD-FP, STORE-FP,
// OP-FP), decodes each into a record with a resolved rounding mode and an
// illegal-encoding flag, and buffers the records in a DEPTH-entry FIFO with
// valid/ready handshakes on both sides.
// Optional feature macro: FPU_FUSED_EN claims the four fused multiply-add
// opcodes and adds rs3 storage to every queue entry.
module fpu_decode_queue #(
  parameter int DEPTH = 4,
  parameter int FLEN  = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  output logic             in_claim,
  input  logic [2:0]       csr_frm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_class,
  output logic [6:0]       out_funct7,
  output logic [2:0]       out_funct3,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rs3,
  output logic [4:0]       out_rd,
  output logic [11:0]      out_imm,
  output logic [2:0]       out_frm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  localparam logic [6:0] OP_LOAD  = 7'b0000111;
  localparam logic [6:0] OP_STORE = 7'b0100111;
  localparam logic [6:0] OP_FP    = 7'b1010011;
`ifdef FPU_FUSED_EN
  localparam logic [6:0] OP_MADD  = 7'b1000011;
  localparam logic [6:0] OP_MSUB  = 7'b1000111;
  localparam logic [6:0] OP_NMSUB = 7'b1001011;
  localparam logic [6:0] OP_NMADD = 7'b1001111;
  localparam logic [1:0] CLS_FUSED = 2'd3;
`endif

  localparam logic [1:0] CLS_ARITH = 2'd0;
  localparam logic [1:0] CLS_LOAD  = 2'd1;
  localparam logic [1:0] CLS_STORE = 2'd2;
  localparam logic [2:0] RM_DYN    = 3'b111;

  // One decoded instruction as held in the queue.
  typedef struct packed {
    logic [1:0]  cls;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
`ifdef FPU_FUSED_EN
    logic [4:0]  rs3;
`endif
    logic [4:0]  rd;
    logic [11:0] imm;
    logic [2:0]  frm;
    logic        illegal;
  } entry_t;

  // Reset image of an entry: all zero, rounding mode "not applicable".
  function automatic entry_t rst_entry();
    entry_t e;
    e     = '0;
    e.frm = RM_DYN;
    return e;
  endfunction

  entry_t             mem [DEPTH];
  entry_t             dec;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;

  logic [6:0]         opcode;
  logic [1:0]         fmt;
  logic [2:0]         rm;
  logic [2:0]         rm_res;
  logic               rm_op;
  logic               rm_bad;
  logic               fmt_ok;
  logic               width_ok;

  // Field extraction and legality terms shared by every instruction class.
  assign opcode   = in_insn[6:0];
  assign fmt      = in_insn[26:25];
  assign rm       = in_insn[14:12];
  assign rm_res   = (rm == RM_DYN) ? csr_frm : rm;
  assign rm_bad   = (rm_res == 3'b101) || (rm_res == 3'b110);
  assign fmt_ok   = (fmt == 2'b00) || ((fmt == 2'b01) && (FLEN == 64));
  assign width_ok = (rm == 3'b010) || ((rm == 3'b011) && (FLEN == 64));
  // Arith ops whose funct3 is a rounding mode: add/sub/mul/div/sqrt and converts.
  assign rm_op    = in_insn[31:27] inside {5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                           5'b01011, 5'b01000, 5'b11000, 5'b11010};

  // Claim and decode the incoming instruction into a queue record.
  always_comb begin
    in_claim   = 1'b0;
    dec        = rst_entry();
    dec.funct3 = rm;
    dec.rs1    = in_insn[19:15];
    unique case (opcode)
      OP_LOAD: begin
        in_claim    = 1'b1;
        dec.cls     = CLS_LOAD;
        dec.rd      = in_insn[11:7];
        dec.imm     = in_insn[31:20];
        dec.illegal = !width_ok;
      end
      OP_STORE: begin
        in_claim    = 1'b1;
        dec.cls     = CLS_STORE;
        dec.rs2     = in_insn[24:20];
        dec.imm     = {in_insn[31:25], in_insn[11:7]};
        dec.illegal = !width_ok;
      end
      OP_FP: begin
        in_claim    = 1'b1;
        dec.cls     = CLS_ARITH;
        dec.funct7  = in_insn[31:25];
        dec.rs2     = in_insn[24:20];
        dec.rd      = in_insn[11:7];
        if (rm_op) begin
          dec.frm     = rm_res;
          dec.illegal = !fmt_ok || rm_bad;
        end else begin
          dec.illegal = !fmt_ok;
        end
      end
`ifdef FPU_FUSED_EN
      OP_MADD, OP_MSUB, OP_NMSUB, OP_NMADD: begin
        in_claim    = 1'b1;
        dec.cls     = CLS_FUSED;
        dec.funct7  = {5'b0, fmt};
        dec.rs2     = in_insn[24:20];
        dec.rs3     = in_insn[31:27];
        dec.rd      = in_insn[11:7];
        dec.frm     = rm_res;
        dec.illegal = !fmt_ok || rm_bad;
      end
`endif
      default: begin
        in_claim = 1'b0;
      end
    endcase
  end

  // Handshakes: a full queue still accepts when the head leaves this cycle.
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = (count < FULL) || pop;
  assign push      = in_valid && in_claim && in_ready;

  // Queue storage, pointers and occupancy; flush and reset discard everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= rst_entry();
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry straight from storage: outputs never depend on the inputs.
  assign head        = mem[rd_ptr];
  assign out_class   = head.cls;
  assign out_funct7  = head.funct7;
  assign out_funct3  = head.funct3;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_imm     = head.imm;
  assign out_frm     = head.frm;
  assign out_illegal = head.illegal;
`ifdef FPU_FUSED_EN
  assign out_rs3     = head.rs3;
`else
  assign out_rs3     = 5'd0;
`endif

endmodule

// File: tb/tb_fpu_decode_queue.sv
module tb_fpu_decode_queue;
  localparam int DEPTH = 4;
  localparam int FLEN  = 32;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_insn;
  logic             in_claim;
  logic [2:0]       csr_frm;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_class;
  logic [6:0]       out_funct7;
  logic [2:0]       out_funct3;
  logic [4:0]       out_rs1, out_rs2, out_rs3, out_rd;
  logic [11:0]      out_imm;
  logic [2:0]       out_frm;
  logic             out_illegal;
  logic [CNT_W-1:0] count;

  fpu_decode_queue #(.DEPTH(DEPTH), .FLEN(FLEN)) dut (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_claim(in_claim), .csr_frm(csr_frm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_funct7(out_funct7), .out_funct3(out_funct3), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rs3(out_rs3), .out_rd(out_rd), .out_imm(out_imm),
    .out_frm(out_frm), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(string nm, bit ok, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        claim;
    logic [1:0]  cls;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rs3, rd;
    logic [11:0] imm;
    logic [2:0]  frm;
    logic        ill;
  } rec_t;

  function automatic rec_t ref_decode(logic [31:0] i, logic [2:0] csr);
    rec_t r;
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [1:0] fm = i[26:25];
    logic       fmt_legal = (fm == 2'b00) || (fm == 2'b01 && FLEN == 64);
    logic       w_legal   = (f3 == 3'b010) || (f3 == 3'b011 && FLEN == 64);
    logic       fused     = 1'b0;
`ifdef FPU_FUSED_EN
    fused = op inside {7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111};
`endif
    r.claim = 0; r.cls = 0; r.f7 = 0; r.f3 = f3; r.rs1 = i[19:15];
    r.rs2 = 0; r.rs3 = 0; r.rd = 0; r.imm = 0; r.frm = 3'b111; r.ill = 0;
    if (op == 7'b0000111) begin
      r.claim = 1; r.cls = 1; r.rd = i[11:7]; r.imm = i[31:20]; r.ill = !w_legal;
    end else if (op == 7'b0100111) begin
      r.claim = 1; r.cls = 2; r.rs2 = i[24:20]; r.imm = {i[31:25], i[11:7]};
      r.ill = !w_legal;
    end else if (op == 7'b1010011 || fused) begin
      r.claim = 1; r.rs2 = i[24:20]; r.rd = i[11:7]; r.ill = !fmt_legal;
      if (fused) begin
        r.cls = 3; r.f7 = {5'b0, fm}; r.rs3 = i[31:27];
      end else begin
        r.cls = 0; r.f7 = i[31:25];
      end
      if (fused || i[31:27] inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd11, 5'd8, 5'd24, 5'd26}) begin
        r.frm = (f3 == 3'b111) ? csr : f3;
        if (r.frm == 3'b101 || r.frm == 3'b110) r.ill = 1;
      end
    end
    return r;
  endfunction

  rec_t q[$];

  task automatic check_outputs();
    chk("count", 32'(count) === 32'(q.size()), count, q.size());
    chk("out_valid", out_valid === (q.size() != 0), out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_class", out_class === q[0].cls, out_class, q[0].cls);
      chk("out_funct7", out_funct7 === q[0].f7, out_funct7, q[0].f7);
      chk("out_funct3", out_funct3 === q[0].f3, out_funct3, q[0].f3);
      chk("out_rs1", out_rs1 === q[0].rs1, out_rs1, q[0].rs1);
      chk("out_rs2", out_rs2 === q[0].rs2, out_rs2, q[0].rs2);
      chk("out_rs3", out_rs3 === q[0].rs3, out_rs3, q[0].rs3);
      chk("out_rd", out_rd === q[0].rd, out_rd, q[0].rd);
      chk("out_imm", out_imm === q[0].imm, out_imm, q[0].imm);
      chk("out_frm", out_frm === q[0].frm, out_frm, q[0].frm);
      chk("out_illegal", out_illegal === q[0].ill, out_illegal, q[0].ill);
    end
  endtask

  task automatic cycle();
    rec_t d;
    logic mpop, mready, mpush;
    #1;
    d      = ref_decode(in_insn, csr_frm);
    mpop   = (q.size() != 0) && out_ready;
    mready = (q.size() < DEPTH) || mpop;
    mpush  = in_valid && d.claim && mready;
    chk("in_claim", in_claim === d.claim, in_claim, d.claim);
    chk("in_ready", in_ready === mready, in_ready, mready);
    @(posedge clk);
    if (rst || flush) q.delete();
    else begin
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back(d);
    end
    #1;
    check_outputs();
  endtask

  task automatic check_reset_state();
    #1;
    chk("rst_count", count === '0, count, 0);
    chk("rst_out_valid", out_valid === 1'b0, out_valid, 0);
    chk("rst_in_ready", in_ready === 1'b1, in_ready, 1);
    chk("rst_class", out_class === 2'd0, out_class, 0);
    chk("rst_funct7", out_funct7 === 7'd0, out_funct7, 0);
    chk("rst_funct3", out_funct3 === 3'd0, out_funct3, 0);
    chk("rst_rs1", out_rs1 === 5'd0, out_rs1, 0);
    chk("rst_rs2", out_rs2 === 5'd0, out_rs2, 0);
    chk("rst_rs3", out_rs3 === 5'd0, out_rs3, 0);
    chk("rst_rd", out_rd === 5'd0, out_rd, 0);
    chk("rst_imm", out_imm === 12'd0, out_imm, 0);
    chk("rst_frm", out_frm === 3'b111, out_frm, 3'b111);
    chk("rst_illegal", out_illegal === 1'b0, out_illegal, 0);
  endtask

  function automatic logic [31:0] gen_insn();
    logic [31:0] r = $urandom;
    logic [4:0]  rmops [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd11, 5'd8, 5'd24, 5'd26};
    logic [6:0]  fops  [4] = '{7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111};
    logic [2:0]  wsel  [3] = '{3'b010, 3'b011, 3'b000};
    int sel = $urandom_range(0, 9);
    if (sel <= 1)      begin r[6:0] = 7'b0000111; r[14:12] = wsel[$urandom_range(0, 2)]; end
    else if (sel == 2) begin r[6:0] = 7'b0100111; r[14:12] = wsel[$urandom_range(0, 2)]; end
    else if (sel <= 5) begin
      r[6:0] = 7'b1010011;
      if ($urandom_range(0, 2) != 0) r[31:27] = rmops[$urandom_range(0, 7)];
    end else if (sel <= 7) r[6:0] = fops[$urandom_range(0, 3)];
    if (sel >= 3 && sel <= 7 && $urandom_range(0, 3) != 0) r[26] = 1'b0;
    return r;
  endfunction

  typedef struct {
    logic [31:0] insn;
    logic [2:0]  csr;
    logic        claim;
    logic [1:0]  cls;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] imm;
    logic [2:0]  frm;
    logic        ill;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{32'h002081D3, 3'b000, 1, 2'd0, 7'h00, 3'd0, 5'd1,  5'd2, 5'd3, 12'h000, 3'b000, 0};
    vecs[1]  = '{32'h00852287, 3'b000, 1, 2'd1, 7'h00, 3'd2, 5'd10, 5'd0, 5'd5, 12'h008, 3'b111, 0};
    vecs[2]  = '{32'h0020F1D3, 3'b011, 1, 2'd0, 7'h00, 3'd7, 5'd1,  5'd2, 5'd3, 12'h000, 3'b011, 0};
    vecs[3]  = '{32'h0020F1D3, 3'b101, 1, 2'd0, 7'h00, 3'd7, 5'd1,  5'd2, 5'd3, 12'h000, 3'b101, 1};
    vecs[4]  = '{32'h00853287, 3'b000, 1, 2'd1, 7'h00, 3'd3, 5'd10, 5'd0, 5'd5, 12'h008, 3'b111, 1};
    vecs[5]  = '{32'h022081D3, 3'b000, 1, 2'd0, 7'h01, 3'd0, 5'd1,  5'd2, 5'd3, 12'h000, 3'b000, 1};
    vecs[6]  = '{32'h00252627, 3'b000, 1, 2'd2, 7'h00, 3'd2, 5'd10, 5'd2, 5'd0, 12'h00C, 3'b111, 0};
    vecs[7]  = '{32'h202081D3, 3'b011, 1, 2'd0, 7'h10, 3'd0, 5'd1,  5'd2, 5'd3, 12'h000, 3'b111, 0};
    vecs[8]  = '{32'h5800F1D3, 3'b010, 1, 2'd0, 7'h2C, 3'd7, 5'd1,  5'd0, 5'd3, 12'h000, 3'b010, 0};
    vecs[9]  = '{32'h0020D1D3, 3'b000, 1, 2'd0, 7'h00, 3'd5, 5'd1,  5'd2, 5'd3, 12'h000, 3'b101, 1};
    vecs[10] = '{32'h042081D3, 3'b000, 1, 2'd0, 7'h02, 3'd0, 5'd1,  5'd2, 5'd3, 12'h000, 3'b000, 1};
    vecs[11] = '{32'hC000F1D3, 3'b110, 1, 2'd0, 7'h60, 3'd7, 5'd1,  5'd0, 5'd3, 12'h000, 3'b110, 1};
    vecs[12] = '{32'hA020A1D3, 3'b000, 1, 2'd0, 7'h50, 3'd2, 5'd1,  5'd2, 5'd3, 12'h000, 3'b111, 0};
    vecs[13] = '{32'h00851287, 3'b000, 1, 2'd1, 7'h00, 3'd1, 5'd10, 5'd0, 5'd5, 12'h008, 3'b111, 1};
    vecs[14] = '{32'h003100B3, 3'b000, 0, 2'd0, 7'h00, 3'd0, 5'd0,  5'd0, 5'd0, 12'h000, 3'b111, 0};
    vecs[15] = '{32'hFE252627, 3'b000, 1, 2'd2, 7'h00, 3'd2, 5'd10, 5'd2, 5'd0, 12'hFEC, 3'b111, 0};
    vecs[16] = '{32'hFFC52287, 3'b000, 1, 2'd1, 7'h00, 3'd2, 5'd10, 5'd0, 5'd5, 12'hFFC, 3'b111, 0};

    rst = 1; in_valid = 0; in_insn = 0; csr_frm = 0; flush = 0; out_ready = 0;
    cycle(); cycle();
    rst = 0;
    check_reset_state();

    foreach (vecs[k]) begin
      in_valid = 1; in_insn = vecs[k].insn; csr_frm = vecs[k].csr; out_ready = 0;
      #1 chk("tbl_claim", in_claim === vecs[k].claim, in_claim, vecs[k].claim);
      cycle();
      in_valid = 0; csr_frm = ~vecs[k].csr;
      #1;
      if (vecs[k].claim) begin
        chk("tbl_valid", out_valid === 1'b1, out_valid, 1);
        chk("tbl_count", 32'(count) === 32'd1, count, 1);
        chk("tbl_class", out_class === vecs[k].cls, out_class, vecs[k].cls);
        chk("tbl_funct7", out_funct7 === vecs[k].f7, out_funct7, vecs[k].f7);
        chk("tbl_funct3", out_funct3 === vecs[k].f3, out_funct3, vecs[k].f3);
        chk("tbl_rs1", out_rs1 === vecs[k].rs1, out_rs1, vecs[k].rs1);
        chk("tbl_rs2", out_rs2 === vecs[k].rs2, out_rs2, vecs[k].rs2);
        chk("tbl_rs3", out_rs3 === 5'd0, out_rs3, 0);
        chk("tbl_rd", out_rd === vecs[k].rd, out_rd, vecs[k].rd);
        chk("tbl_imm", out_imm === vecs[k].imm, out_imm, vecs[k].imm);
        chk("tbl_frm", out_frm === vecs[k].frm, out_frm, vecs[k].frm);
        chk("tbl_illegal", out_illegal === vecs[k].ill, out_illegal, vecs[k].ill);
        out_ready = 1;
        cycle();
        out_ready = 0;
      end else begin
        chk("tbl_unclaimed_count", count === '0, count, 0);
        chk("tbl_unclaimed_valid", out_valid === 1'b0, out_valid, 0);
      end
    end

    for (int r = 1; r <= 5; r++) begin
      in_valid = 1; in_insn = 32'h00852007 | (32'(r) << 7);
      cycle();
    end
    #1;
    chk("full_in_ready", in_ready === 1'b0, in_ready, 0);
    chk("full_count", 32'(count) === 32'd4, count, 4);
    for (int k = 0; k < 6; k++) begin
      in_insn = 32'h00852007 | (32'(5 + k) << 7); out_ready = 1;
      cycle();
      chk("stream_count", 32'(count) === 32'd4, count, 4);
      chk("stream_head_rd", 32'(out_rd) === 32'(2 + k), out_rd, 2 + k);
    end
    in_valid = 0;
    for (int k = 0; k < 4; k++) cycle();
    chk("drained_count", count === '0, count, 0);

    out_ready = 0; in_valid = 1; in_insn = 32'h002081D3;
    for (int k = 0; k < 3; k++) cycle();
    chk("pre_flush_count", 32'(count) === 32'd3, count, 3);
    flush = 1;
    cycle();
    flush = 0; in_valid = 0;
    chk("flush_count", count === '0, count, 0);
    chk("flush_valid", out_valid === 1'b0, out_valid, 0);
    cycle();
    chk("post_flush_count", count === '0, count, 0);

    in_valid = 1; in_insn = 32'h00252627;
    cycle(); cycle();
    rst = 1;
    cycle();
    rst = 0; in_valid = 0;
    check_reset_state();

    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_insn   = gen_insn();
      csr_frm   = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 300) == 0);
      cycle();
    end
    rst = 0; flush = 0; in_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
